// File: rtl/mips_mem_pkg.sv
// Shared types and helpers for the MEM stage: access-size encodings,
// alignment/byte-enable helpers and the MEM/WB register payload.
package mips_mem_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;
    localparam int unsigned REG_W  = 5;

    typedef enum logic [1:0] {
        MEM_SIZE_B   = 2'b00,
        MEM_SIZE_H   = 2'b01,
        MEM_SIZE_W   = 2'b10,
        MEM_SIZE_RSV = 2'b11
    } mem_size_e;

    // MEM/WB pipeline register payload
    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] dato;
        logic [DATA_W-1:0] alu;
        logic [REG_W-1:0]  rd;
        logic [REG_W-1:0]  rt;
        logic              reg_write;
        logic              wb_mux;
        logic              wr_mux;
        logic              misalign;
    } memwb_t;

    // Natural alignment check; the reserved size is never legal
    function automatic logic access_aligned(input mem_size_e size, input logic [1:0] addr);
        logic ok;
        ok = 1'b0;
        case (size)
            MEM_SIZE_B: ok = 1'b1;
            MEM_SIZE_H: ok = ~addr[0];
            MEM_SIZE_W: ok = (addr == 2'b00);
            default:    ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Little-endian byte lanes touched by an access
    function automatic logic [BE_W-1:0] byte_enable(input mem_size_e size, input logic [1:0] addr);
        logic [BE_W-1:0] be;
        be = '0;
        case (size)
            MEM_SIZE_B: be = 4'b0001 << addr;
            MEM_SIZE_H: be = addr[1] ? 4'b1100 : 4'b0011;
            MEM_SIZE_W: be = 4'b1111;
            default:    be = '0;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/mem_access_stage_data_mem.sv
// Data memory: DEPTH_WORDS x 32 array, per-byte write enables, async read.
// Ports: clk; i_be byte write enables; i_addr word index; i_wdata lane data;
//        o_rdata_c combinational read of the addressed word.
// Contents are deliberately not reset.
module data_mem
    import mips_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256
) (
    input  logic                           clk,
    input  logic [BE_W-1:0]                i_be,
    input  logic [$clog2(DEPTH_WORDS)-1:0] i_addr,
    input  logic [DATA_W-1:0]              i_wdata,
    output logic [DATA_W-1:0]              o_rdata_c
);

    logic [DATA_W-1:0] r_mem [DEPTH_WORDS];

    // Byte-lane writes
    always_ff @(posedge clk) begin
        for (int b = 0; b < int'(BE_W); b++) begin
            if (i_be[b]) begin
                r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
    end

    assign o_rdata_c = r_mem[i_addr];

endmodule

// File: rtl/mem_access_stage.sv
// MIPS MEM stage plus MEM/WB register.
// Ports: clk, reset_n (async active-low); stall/flush pipeline control;
//        ex_* EX/MEM bundle (valid, ALU address, store data, rd/rt, read/write,
//        size, unsigned, reg_write, WB/WR mux flags);
//        registered WB outputs wb_valid, dato_mem, ALU, rd, rt, reg_write,
//        WB_mux_flag, WR_mux_flag, and mem_misalign (illegal access flag).
module mem_access_stage
    import mips_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ex_alu,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [REG_W-1:0]  ex_rd,
    input  logic [REG_W-1:0]  ex_rt,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic [1:0]        ex_mem_size,
    input  logic              ex_mem_unsigned,
    input  logic              ex_reg_write,
    input  logic              ex_wb_mux_flag,
    input  logic              ex_wr_mux_flag,
    output logic              wb_valid,
    output logic [DATA_W-1:0] dato_mem,
    output logic [DATA_W-1:0] ALU,
    output logic [REG_W-1:0]  rd,
    output logic [REG_W-1:0]  rt,
    output logic              reg_write,
    output logic              WB_mux_flag,
    output logic              WR_mux_flag,
    output logic              mem_misalign
);

    localparam int unsigned ADDR_W = $clog2(DEPTH_WORDS);

    mem_size_e         w_size;
    logic [1:0]        w_lane_addr;
    logic [ADDR_W-1:0] w_idx;
    logic              w_access;
    logic              w_illegal;
    logic              w_store;
    logic              w_load;
    logic [BE_W-1:0]   w_be;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_rdata;
    logic [DATA_W-1:0] w_lane;
    logic [DATA_W-1:0] w_load_ext;
    memwb_t            w_next;
    memwb_t            r_wb;
    logic              w_unused_addr;

    assign w_size        = mem_size_e'(ex_mem_size);
    assign w_lane_addr   = ex_alu[1:0];
    // Upper address bits are dropped so accesses wrap modulo the array size
    assign w_idx         = ex_alu[ADDR_W+1:2];
    assign w_unused_addr = ^ex_alu[DATA_W-1:ADDR_W+2];

    assign w_access  = ex_valid & (ex_mem_read | ex_mem_write);
    assign w_illegal = w_access & ~access_aligned(w_size, w_lane_addr);

    // Only an advancing edge commits a store; reset_n gating drops a store caught by reset
    assign w_store = ex_valid & ex_mem_write & ~w_illegal & ~stall & ~flush & reset_n;
    // Read+write together behaves as a store, so no load data is returned
    assign w_load  = ex_valid & ex_mem_read & ~ex_mem_write & ~w_illegal;

    assign w_be = w_store ? byte_enable(w_size, w_lane_addr) : '0;

    // Replicate store data across lanes; byte enables pick the target lane(s)
    always_comb begin
        w_wdata = ex_store_data;
        case (w_size)
            MEM_SIZE_B: w_wdata = {4{ex_store_data[7:0]}};
            MEM_SIZE_H: w_wdata = {2{ex_store_data[15:0]}};
            default:    w_wdata = ex_store_data;
        endcase
    end

    data_mem #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_data_mem (
        .clk       (clk),
        .i_be      (w_be),
        .i_addr    (w_idx),
        .i_wdata   (w_wdata),
        .o_rdata_c (w_rdata)
    );

    // Bring the addressed lane down to bit 0, then extend
    assign w_lane = w_rdata >> {w_lane_addr, 3'b000};

    always_comb begin
        w_load_ext = '0;
        if (w_load) begin
            case (w_size)
                MEM_SIZE_B: w_load_ext = ex_mem_unsigned ? {24'h0, w_lane[7:0]}
                                                         : {{24{w_lane[7]}}, w_lane[7:0]};
                MEM_SIZE_H: w_load_ext = ex_mem_unsigned ? {16'h0, w_lane[15:0]}
                                                         : {{16{w_lane[15]}}, w_lane[15:0]};
                default:    w_load_ext = w_rdata;
            endcase
        end
    end

    // Next MEM/WB contents on an advancing edge
    always_comb begin
        w_next           = '0;
        w_next.valid     = ex_valid;
        w_next.dato      = w_load_ext;
        w_next.alu       = ex_alu;
        w_next.rd        = ex_rd;
        w_next.rt        = ex_rt;
        w_next.reg_write = ex_valid & ex_reg_write & ~w_illegal;
        w_next.wb_mux    = ex_wb_mux_flag;
        w_next.wr_mux    = ex_wr_mux_flag;
        w_next.misalign  = w_illegal;
    end

    // MEM/WB register: reset > flush > stall > advance
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wb <= '0;
        end else if (flush) begin
            r_wb <= '0;
        end else if (!stall) begin
            r_wb <= w_next;
        end
    end

    assign wb_valid     = r_wb.valid;
    assign dato_mem     = r_wb.dato;
    assign ALU          = r_wb.alu;
    assign rd           = r_wb.rd;
    assign rt           = r_wb.rt;
    assign reg_write    = r_wb.reg_write;
    assign WB_mux_flag  = r_wb.wb_mux;
    assign WR_mux_flag  = r_wb.wr_mux;
    assign mem_misalign = r_wb.misalign;

endmodule
